// File: rtl/vga_field_compositor.sv
// ----------------------------------------------------------------------------
// vga_field_compositor
//
// Scans a base image out of ROM at an integer upscale onto the 640x480 raster
// and overlays NUM_FIELDS 7x10 digit glyphs on the fly, with no framebuffer.
// Sits between the VGA timing generator and the DAC.
//
// Field values and positions are double-buffered. The shadow copies reload only
// at frame start (pos_V==0, pos_H==0), so a digit never tears mid-frame.
//
// Latency: pos_H/pos_V/ready sampled on one clock give RGB two clocks later.
// Stage 1 registers the ROM addresses; stage 2 registers the composited pixel.
//
// Ports
//   vga_CLK     in   1              pixel clock
//   vga_RSTn    in   1              asynchronous, active-low reset
//   ready       in   1              active-video flag from the timing generator
//   pos_H       in  10              raster column
//   pos_V       in  10              raster row
//   field_val   in   4*NUM_FIELDS   BCD digit per field, 4'hA..4'hF = blank
//   field_x     in   9*NUM_FIELDS   field top-left x, image space
//   field_y     in   8*NUM_FIELDS   field top-left y, image space
//   update      in   1              pulse: reload the shadows at the next frame start
//   hilite_sel  in   4              (VGA_FIELD_HILITE_EN only) field drawn inverted
//   update_ack  out  1              one-cycle pulse when the shadows reload
//   RGB         out 12              RGB444 pixel
//
// Optional feature: define VGA_FIELD_HILITE_EN to add hilite_sel. Opaque glyph
// pixels of the selected field are then output bitwise-inverted.
// ----------------------------------------------------------------------------
module vga_field_compositor #(
    parameter int          IMG_W      = 320,
    parameter int          IMG_H      = 240,
    parameter int          SCALE      = 2,
    parameter int          H_START    = 144,
    parameter int          V_START    = 35,
    parameter int          NUM_FIELDS = 6,
    parameter int          GLYPH_W    = 7,
    parameter int          GLYPH_H    = 10,
    parameter logic [11:0] KEY_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic                    vga_CLK,
    input  logic                    vga_RSTn,
    input  logic                    ready,
    input  logic [9:0]              pos_H,
    input  logic [9:0]              pos_V,
    input  logic [4*NUM_FIELDS-1:0] field_val,
    input  logic [9*NUM_FIELDS-1:0] field_x,
    input  logic [8*NUM_FIELDS-1:0] field_y,
    input  logic                    update,
`ifdef VGA_FIELD_HILITE_EN
    input  logic [3:0]              hilite_sel,
`endif
    output logic                    update_ack,
    output logic [11:0]             RGB
);

    localparam int ADDR_W  = $clog2(IMG_W * IMG_H);
    localparam int GADDR_W = $clog2(10 * GLYPH_W * GLYPH_H);

    localparam logic [9:0]        H_FIRST  = 10'(H_START);
    localparam logic [9:0]        H_LAST   = 10'(H_START + SCALE * IMG_W - 1);
    localparam logic [9:0]        V_FIRST  = 10'(V_START);
    localparam logic [9:0]        V_LAST   = 10'(V_START + SCALE * IMG_H - 1);
    localparam logic [1:0]        SUB_LAST = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    // Scan state
    logic [1:0]        sub_h, sub_v;
    logic [8:0]        img_x;
    logic [7:0]        img_y;
    logic [ADDR_W-1:0] row_base;

    // Shadow field registers and handshake
    logic [3:0] sh_val [NUM_FIELDS];
    logic [8:0] sh_x   [NUM_FIELDS];
    logic [7:0] sh_y   [NUM_FIELDS];
    logic       pending;

    logic in_img_h, in_img_v, in_img, frame_start;

    assign in_img_h    = (pos_H >= H_FIRST) && (pos_H <= H_LAST);
    assign in_img_v    = (pos_V >= V_FIRST) && (pos_V <= V_LAST);
    assign in_img      = in_img_h && in_img_v;
    assign frame_start = (pos_V == 10'd0) && (pos_H == 10'd0);

    // Image scan counters. The values held here are the image coordinates of
    // the pixel currently on pos_H/pos_V. The row base only moves at the last
    // active column of a row, so the address path is a single adder, row_base
    // plus img_x, with no multiplier.
    always_ff @(posedge vga_CLK or negedge vga_RSTn) begin
        if (!vga_RSTn) begin
            sub_h    <= '0;
            sub_v    <= '0;
            img_x    <= '0;
            img_y    <= '0;
            row_base <= '0;
        end else if (pos_V == 10'd0) begin
            sub_h    <= '0;
            sub_v    <= '0;
            img_x    <= '0;
            img_y    <= '0;
            row_base <= '0;
        end else begin
            if (pos_H == 10'd0) begin
                sub_h <= '0;
                img_x <= '0;
            end else if (ready && in_img) begin
                if (sub_h == SUB_LAST) begin
                    sub_h <= '0;
                    img_x <= img_x + 9'd1;
                end else begin
                    sub_h <= sub_h + 2'd1;
                end
            end
            if (ready && in_img_v && (pos_H == H_LAST)) begin
                if (sub_v == SUB_LAST) begin
                    sub_v    <= '0;
                    img_y    <= img_y + 8'd1;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    sub_v <= sub_v + 2'd1;
                end
            end
        end
    end

    // Reload handshake. An update seen on the reload cycle itself re-arms
    // pending, so that request is served at the following frame start.
    // Several updates within one frame merge into a single reload.
    always_ff @(posedge vga_CLK or negedge vga_RSTn) begin
        if (!vga_RSTn) begin
            pending    <= 1'b0;
            update_ack <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                sh_val[i] <= 4'hF;
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
            end
        end else begin
            update_ack <= frame_start && pending;
            if (frame_start && pending) begin
                pending <= update;
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    sh_val[i] <= field_val[4*i +: 4];
                    sh_x[i]   <= field_x[9*i +: 9];
                    sh_y[i]   <= field_y[8*i +: 8];
                end
            end else if (update) begin
                pending <= 1'b1;
            end
        end
    end

    // Field hit test. The loop scans from the highest index down, so the
    // lowest-index hit is written last and wins on overlap. The >= guards
    // stop the glyph coordinates from wrapping, which clips the glyph at
    // the image edges.
    logic               hit;
    logic [GADDR_W-1:0] glyph_addr;
    logic [8:0]         dx;
    logic [7:0]         dy;
`ifdef VGA_FIELD_HILITE_EN
    logic [3:0]         hit_idx;
`endif

    always_comb begin
        hit        = 1'b0;
        glyph_addr = '0;
        dx         = '0;
        dy         = '0;
`ifdef VGA_FIELD_HILITE_EN
        hit_idx    = '0;
`endif
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            dx = img_x - sh_x[i];
            dy = img_y - sh_y[i];
            if ((img_x >= sh_x[i]) && (dx < 9'(GLYPH_W)) &&
                (img_y >= sh_y[i]) && (dy < 8'(GLYPH_H)) &&
                (sh_val[i] <= 4'd9)) begin
                hit        = 1'b1;
                glyph_addr = GADDR_W'(sh_val[i]) * GADDR_W'(GLYPH_W * GLYPH_H)
                           + GADDR_W'(dy) * GADDR_W'(GLYPH_W) + GADDR_W'(dx);
`ifdef VGA_FIELD_HILITE_EN
                hit_idx    = 4'(i);
`endif
            end
        end
    end

    // Stage 1: register the ROM addresses together with the flags that
    // travel alongside the pixel.
    logic               s1_ready, s1_in_img, s1_hit;
    logic [ADDR_W-1:0]  s1_img_addr;
    logic [GADDR_W-1:0] s1_glyph_addr;
`ifdef VGA_FIELD_HILITE_EN
    logic               s1_inv;
`endif

    always_ff @(posedge vga_CLK or negedge vga_RSTn) begin
        if (!vga_RSTn) begin
            s1_ready      <= 1'b0;
            s1_in_img     <= 1'b0;
            s1_hit        <= 1'b0;
            s1_img_addr   <= '0;
            s1_glyph_addr <= '0;
`ifdef VGA_FIELD_HILITE_EN
            s1_inv        <= 1'b0;
`endif
        end else begin
            s1_ready      <= ready;
            s1_in_img     <= in_img;
            s1_hit        <= hit;
            s1_img_addr   <= row_base + ADDR_W'(img_x);
            s1_glyph_addr <= glyph_addr;
`ifdef VGA_FIELD_HILITE_EN
            s1_inv        <= hit && (hit_idx == hilite_sel);
`endif
        end
    end

    // Pattern ROMs: each word holds the low 12 bits of its own address.
    // Replace these with the real artwork and font ROMs; both are read
    // asynchronously from the stage-1 addresses.
    logic [11:0] img_pix, glyph_pix, glyph_out;

    assign img_pix   = 12'(s1_img_addr);
    assign glyph_pix = 12'(s1_glyph_addr);
`ifdef VGA_FIELD_HILITE_EN
    assign glyph_out = s1_inv ? ~glyph_pix : glyph_pix;
`else
    assign glyph_out = glyph_pix;
`endif

    // Stage 2: composite. Blanking has priority over the border colour, and
    // the border colour has priority over the image and glyph pixels.
    always_ff @(posedge vga_CLK or negedge vga_RSTn) begin
        if (!vga_RSTn) begin
            RGB <= 12'h000;
        end else if (!s1_ready) begin
            RGB <= 12'h000;
        end else if (!s1_in_img) begin
            RGB <= BG_COLOR;
        end else if (s1_hit && (glyph_pix != KEY_COLOR)) begin
            RGB <= glyph_out;
        end else begin
            RGB <= img_pix;
        end
    end

endmodule

// File: tb/tb_vga_field_compositor.sv
// ----------------------------------------------------------------------------
// tb_vga_field_compositor
//
// Directed bench for vga_field_compositor with its default parameters:
// SCALE=2, a 320x240 image, H_START=144, V_START=35 and 6 fields. Both pattern
// ROMs return the low 12 bits of the word address.
//
// The bench drives a compressed raster. A row is skipped by driving only
// pos_H=0 followed by the last active column, which is enough to move the row
// counters. Only the row that holds the pixel of interest is scanned in full.
// ----------------------------------------------------------------------------
module tb_vga_field_compositor;

    localparam int NF = 6;

    logic            vga_CLK = 1'b0;
    logic            vga_RSTn;
    logic            ready;
    logic [9:0]      pos_H, pos_V;
    logic [4*NF-1:0] field_val;
    logic [9*NF-1:0] field_x;
    logic [8*NF-1:0] field_y;
    logic            update;
    logic            update_ack;
    logic [11:0]     RGB;
`ifdef VGA_FIELD_HILITE_EN
    logic [3:0]      hilite_sel;
`endif

    int total = 0;
    int bad   = 0;

    // Two-deep record of what was driven, so that RGB can be checked two
    // clocks after its raster position was applied.
    logic        chk_d1 = 1'b0, chk_d2 = 1'b0;
    logic [11:0] exp_d1 = '0,   exp_d2 = '0;
    string       nm_d1  = "",   nm_d2  = "";

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        r;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[11];

    always #5 vga_CLK = ~vga_CLK;

    vga_field_compositor dut (
        .vga_CLK    (vga_CLK),
        .vga_RSTn   (vga_RSTn),
        .ready      (ready),
        .pos_H      (pos_H),
        .pos_V      (pos_V),
        .field_val  (field_val),
        .field_x    (field_x),
        .field_y    (field_y),
        .update     (update),
`ifdef VGA_FIELD_HILITE_EN
        .hilite_sel (hilite_sel),
`endif
        .update_ack (update_ack),
        .RGB        (RGB)
    );

    // Compare one value and keep the counts.
    task automatic checkOutput(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 12'h%h, want 12'h%h", nm, act, exp);
        end
    endtask

    // Drive one pixel on the falling edge. Before driving, check the pixel
    // that was driven two calls earlier.
    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic r,
                                 input logic chk, input logic [11:0] exp, input string nm);
        @(negedge vga_CLK);
        if (chk_d2) checkOutput(nm_d2, RGB, exp_d2);
        chk_d2 = chk_d1; exp_d2 = exp_d1; nm_d2 = nm_d1;
        chk_d1 = chk;    exp_d1 = exp;    nm_d1 = nm;
        pos_H = h; pos_V = v; ready = r;
    endtask

    task automatic go(input int h, input int v, input logic r);
        applyStimulus(10'(h), 10'(v), r, 1'b0, 12'h000, "");
    endtask

    task automatic probe(input int h, input int v, input logic [11:0] exp, input string nm);
        applyStimulus(10'(h), 10'(v), 1'b1, 1'b1, exp, nm);
    endtask

    task automatic flush();
        go(int'(pos_H), int'(pos_V), 1'b0);
        go(int'(pos_H), int'(pos_V), 1'b0);
    endtask

    task automatic skipRows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            go(0, r, 1'b0);
            go(783, r, 1'b1);
        end
    endtask

    // Start a frame, walk down to row v, scan it up to column h, then check.
    task automatic scanTo(input int h, input int v, input logic r, input logic [11:0] exp, input string nm);
        go(0, 0, 1'b0);
        skipRows(35, v - 1);
        go(0, v, 1'b0);
        for (int c = 144; c < h && c < 784; c++) go(c, v, 1'b1);
        applyStimulus(10'(h), 10'(v), r, 1'b1, exp, nm);
        flush();
    endtask

    task automatic setField(input int idx, input logic [3:0] val, input int x, input int y);
        field_val[idx*4 +: 4] = val;
        field_x[idx*9 +: 9]   = 9'(x);
        field_y[idx*8 +: 8]   = 8'(y);
    endtask

    task automatic pulseUpdate();
        update = 1'b1;
        go(7, 5, 1'b0);
        update = 1'b0;
    endtask

    task automatic checkAck(input string nm, input logic exp);
        checkOutput(nm, {11'b0, update_ack}, {11'b0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, want test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{10'd144, 10'd35,  1'b1, 12'h000};
        vecs[1]  = '{10'd145, 10'd36,  1'b1, 12'h000};
        vecs[2]  = '{10'd146, 10'd36,  1'b1, 12'h001};
        vecs[3]  = '{10'd144, 10'd37,  1'b1, 12'h140};
        vecs[4]  = '{10'd146, 10'd37,  1'b1, 12'h141};
        vecs[5]  = '{10'd783, 10'd35,  1'b1, 12'h13F};
        vecs[6]  = '{10'd784, 10'd35,  1'b1, 12'h000};
        vecs[7]  = '{10'd150, 10'd514, 1'b1, 12'hAC3};
        vecs[8]  = '{10'd150, 10'd515, 1'b1, 12'h000};
        vecs[9]  = '{10'd300, 10'd100, 1'b1, 12'h84E};
        vecs[10] = '{10'd200, 10'd40,  1'b0, 12'h000};

        vga_RSTn  = 1'b0;
        ready     = 1'b0;
        pos_H     = '0;
        pos_V     = '0;
        update    = 1'b0;
        field_val = {4*NF{1'b1}};
        field_x   = '0;
        field_y   = '0;
`ifdef VGA_FIELD_HILITE_EN
        hilite_sel = 4'hF;
`endif
        setField(0, 4'd0, 0, 0);

        // Hold reset over two compressed frames, with update pulses.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 40; k++) begin
                @(negedge vga_CLK);
                checkOutput("rst_rgb", RGB, 12'h000);
                checkAck("rst_ack", 1'b0);
                pos_H  = (k == 0) ? 10'd0 : 10'(144 + k);
                pos_V  = (k == 0) ? 10'd0 : 10'(35 + k / 8);
                ready  = (k != 0);
                update = (k == 5);
            end
        end
        update = 1'b0;
        @(negedge vga_CLK);
        vga_RSTn = 1'b1;

        // Image-only frames: field0 is set on the inputs but never reloaded.
        for (int i = 0; i < 11; i++)
            scanTo(int'(vecs[i].h), int'(vecs[i].v), vecs[i].r, vecs[i].exp, $sformatf("vec%0d", i));

        // Update mid-frame: the field must not appear until the next frame.
        setField(0, 4'd3, 10, 20);
        go(0, 0, 1'b0);
        skipRows(35, 50);
        update = 1'b1;
        go(0, 51, 1'b0);
        update = 1'b0;
        skipRows(51, 74);
        go(0, 75, 1'b0);
        for (int c = 144; c < 164; c++) go(c, 75, 1'b1);
        probe(164, 75, 12'h90A, "pre_reload");
        flush();
        checkAck("ack_midframe", 1'b0);
        go(0, 0, 1'b0);
        go(5, 0, 1'b0);
        checkAck("ack_pulse", 1'b1);
        go(6, 0, 1'b0);
        checkAck("ack_single", 1'b0);
        skipRows(35, 74);
        go(0, 75, 1'b0);
        for (int c = 144; c < 164; c++) go(c, 75, 1'b1);
        probe(164, 75, 12'h0D2, "glyph_210");
        probe(165, 75, 12'h0D2, "glyph_210b");
        probe(166, 75, 12'h0D3, "glyph_211");
        for (int c = 167; c < 176; c++) go(c, 75, 1'b1);
        probe(176, 75, 12'h0D8, "glyph_last_col");
        go(177, 75, 1'b1);
        probe(178, 75, 12'h911, "glyph_right_edge");
        flush();

        // Two updates in one frame produce a single reload.
        go(0, 0, 1'b0);
        go(9, 5, 1'b0);
        update = 1'b1; go(10, 5, 1'b0); update = 1'b0;
        go(11, 5, 1'b0);
        update = 1'b1; go(12, 5, 1'b0); update = 1'b0;
        go(0, 0, 1'b0);
        go(1, 0, 1'b0);
        checkAck("ack_collapse", 1'b1);
        go(2, 0, 1'b0);
        go(0, 0, 1'b0);
        go(1, 0, 1'b0);
        checkAck("ack_once", 1'b0);

        // An update coinciding with the reload cycle re-arms the next frame.
        go(4, 5, 1'b0);
        update = 1'b1; go(5, 5, 1'b0); update = 1'b0;
        go(0, 0, 1'b0);
        update = 1'b1; go(1, 0, 1'b0); update = 1'b0;
        checkAck("ack_coinc", 1'b1);
        go(2, 0, 1'b0);
        checkAck("ack_coinc_end", 1'b0);
        go(3, 5, 1'b0);
        go(0, 0, 1'b0);
        go(1, 0, 1'b0);
        checkAck("ack_repend", 1'b1);
        go(2, 0, 1'b0);
        go(0, 0, 1'b0);
        go(1, 0, 1'b0);
        checkAck("ack_drain", 1'b0);

        // Overlap: the lower index wins; with field0 blanked, field1 shows.
        setField(0, 4'd1, 50, 50);
        setField(1, 4'd2, 50, 50);
        pulseUpdate();
        scanTo(244, 135, 1'b1, 12'h046, "overlap_f0");
        setField(0, 4'hF, 50, 50);
        pulseUpdate();
        scanTo(244, 135, 1'b1, 12'h08C, "overlap_f1");

        // Clipping at the right edge of the image.
        setField(1, 4'hF, 0, 0);
        setField(0, 4'd0, 316, 0);
        pulseUpdate();
        go(0, 0, 1'b0);
        go(0, 35, 1'b0);
        for (int c = 144; c < 774; c++) go(c, 35, 1'b1);
        probe(774, 35, 12'h13B, "clip_img315");
        probe(775, 35, 12'h13B, "clip_img315b");
        probe(776, 35, 12'h000, "clip_gx0");
        for (int c = 777; c < 782; c++) go(c, 35, 1'b1);
        probe(782, 35, 12'h003, "clip_gx3");
        probe(783, 35, 12'h003, "clip_gx3b");
        probe(784, 35, 12'h000, "clip_bg");
        probe(790, 35, 12'h000, "clip_bg2");
        go(0, 36, 1'b0);
        go(783, 36, 1'b1);
        go(0, 37, 1'b0);
        probe(144, 37, 12'h140, "clip_nowrap");
        flush();

        // Reset asserted mid-row: output drops at once, scan recovers.
        go(0, 0, 1'b0);
        go(0, 35, 1'b0);
        for (int c = 144; c < 200; c++) go(c, 35, 1'b1);
        #2 vga_RSTn = 1'b0;
        #1 checkOutput("rst_async", RGB, 12'h000);
        checkAck("rst_async_ack", 1'b0);
        chk_d1 = 1'b0;
        chk_d2 = 1'b0;
        @(negedge vga_CLK);
        vga_RSTn = 1'b1;
        scanTo(300, 100, 1'b1, 12'h84E, "post_reset");

`ifdef VGA_FIELD_HILITE_EN
        // Highlighted glyph pixels are inverted; hilite_sel=15 selects no field.
        setField(0, 4'd3, 0, 0);
        pulseUpdate();
        hilite_sel = 4'd0;
        scanTo(148, 43, 1'b1, 12'hF0F, "hilite_on");
        hilite_sel = 4'd15;
        scanTo(148, 43, 1'b1, 12'h0F0, "hilite_off");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
